// File: rtl/fb_pkg.sv
// Shared types for the framebuffer burst reader: FSM state encoding and
// a constant-width helper for the word counter.
package fb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CMD   = 2'd1,
        DRAIN = 2'd2
    } fb_rd_state_t;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/fb_burst_reader.sv
// Burst read engine: turns display burst requests into fixed-length SDRAM read
// commands (at most MAXOUT outstanding) and forwards returned words one cycle later.
module fb_burst_reader
    import fb_pkg::*;
#(
    parameter int AN     = 24,
    parameter int DN     = 16,
    parameter int BURST  = 8,
    parameter int MAXOUT = 2
) (
    input  logic          clkSYS,
    input  logic          n_reset,
    input  logic          flush,
    input  logic          req,
    input  logic [AN-1:0] req_addr,
    output logic          req_ack,
    output logic [DN-1:0] mem_data,
    output logic          mem_valid,
    output logic          cmd_req,
    output logic [AN-1:0] cmd_addr,
    input  logic          cmd_ack,
    input  logic [DN-1:0] rsp_data,
    input  logic          rsp_valid,
    output logic [1:0]    pending,
    output logic          busy,
    output fb_rd_state_t  state_dbg
);

    localparam int         CW       = clog2(BURST);
    localparam logic [1:0] MAXOUT_W = 2'(MAXOUT);
    localparam logic [CW-1:0] LAST_WORD = CW'(BURST - 1);

    // Handshakes: a request transfers in the cycle req_ack is 1 (req_addr sampled
    // then); a command transfers in the cycle cmd_req and cmd_ack are both 1, and
    // cmd_req never drops before that; rsp_valid and mem_valid are unthrottled strobes.

    fb_rd_state_t  state;
    fb_rd_state_t  state_nxt;
    logic [CW-1:0] word_cnt;
    logic          flush_seen;
    logic          cmd_seen;
    logic          cmd_accept;
    logic          word_take;
    logic          burst_end;
    logic          room;

    assign room       = (pending < MAXOUT_W);
    assign cmd_accept = cmd_req && cmd_ack;
    // Words with nothing outstanding belong to no command and are dropped.
    assign word_take  = rsp_valid && (pending != 2'd0);
    assign burst_end  = word_take && (word_cnt == LAST_WORD);
    assign busy       = (state != IDLE) || (pending != 2'd0);
    assign state_dbg  = state;

    always_comb begin
        state_nxt = state;
        req_ack   = 1'b0;
        cmd_req   = 1'b0;
        case (state)
            IDLE: begin
                if (flush) begin
                    state_nxt = DRAIN;
                end else if (req && room) begin
                    req_ack   = 1'b1;
                    state_nxt = CMD;
                end
            end
            CMD: begin
                // A flushed command is still completed; the controller cannot retract it.
                cmd_req = 1'b1;
                if (cmd_ack) begin
                    state_nxt = (flush || flush_seen) ? DRAIN : IDLE;
                end
            end
            DRAIN: begin
                if ((pending == 2'd0) && !flush) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clkSYS or negedge n_reset) begin
        if (!n_reset) begin
            state      <= IDLE;
            pending    <= 2'd0;
            word_cnt   <= '0;
            flush_seen <= 1'b0;
            cmd_seen   <= 1'b0;
            cmd_addr   <= '0;
            mem_data   <= '0;
            mem_valid  <= 1'b0;
        end else begin
            state      <= state_nxt;
            flush_seen <= (state == CMD) && !cmd_ack && (flush || flush_seen);
            if (cmd_accept) begin
                cmd_seen <= 1'b1;
            end
            if (req_ack) begin
                cmd_addr <= req_addr;
            end
            if (word_take) begin
                word_cnt <= word_cnt + 1'b1;
            end
            if (cmd_accept && !burst_end) begin
                pending <= pending + 2'd1;
            end else if (!cmd_accept && burst_end) begin
                pending <= pending - 2'd1;
            end
            if (rsp_valid) begin
                mem_data <= rsp_data;
            end
            mem_valid <= word_take && (state != DRAIN) && !flush && !flush_seen;
        end
    end

    // Words left over from a burst abandoned by reset are tolerated until the
    // first command after reset completes.
    a_no_stray_rsp : assert property (@(posedge clkSYS) disable iff (!n_reset)
        !(rsp_valid && (pending == 2'd0) && cmd_seen));

    a_pending_max : assert property (@(posedge clkSYS) disable iff (!n_reset)
        pending <= MAXOUT_W);

endmodule

// File: tb/tb_fb_burst_reader.sv
// Scoreboard bench for fb_burst_reader: directed scenarios plus randomized bursts,
// with expected words queued by a transaction-level model and popped by a monitor.
module tb_fb_burst_reader;
    import fb_pkg::*;

    localparam int AN     = 24;
    localparam int DN     = 16;
    localparam int BURST  = 8;
    localparam int MAXOUT = 2;

    logic          clkSYS = 1'b0;
    logic          n_reset = 1'b0;
    logic          flush = 1'b0;
    logic          req = 1'b0;
    logic [AN-1:0] req_addr = '0;
    logic          cmd_ack = 1'b0;
    logic [DN-1:0] rsp_data = '0;
    logic          rsp_valid = 1'b0;
    logic          req_ack;
    logic [DN-1:0] mem_data;
    logic          mem_valid;
    logic          cmd_req;
    logic [AN-1:0] cmd_addr;
    logic [1:0]    pending;
    logic          busy;
    fb_rd_state_t  state_dbg;

    fb_burst_reader #(.AN(AN), .DN(DN), .BURST(BURST), .MAXOUT(MAXOUT)) dut (
        .clkSYS(clkSYS), .n_reset(n_reset), .flush(flush), .req(req),
        .req_addr(req_addr), .req_ack(req_ack), .mem_data(mem_data),
        .mem_valid(mem_valid), .cmd_req(cmd_req), .cmd_addr(cmd_addr),
        .cmd_ack(cmd_ack), .rsp_data(rsp_data), .rsp_valid(rsp_valid),
        .pending(pending), .busy(busy), .state_dbg(state_dbg)
    );

    // clock / reset block
    always #5 clkSYS = ~clkSYS;

    int            checks = 0;
    int            passes = 0;
    logic [DN-1:0] exp_q[$];
    int            model_pending = 0;
    int            model_cnt = 0;
    bit            discard = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clkSYS);
        #1;
    endtask

    // Reference model: a word belongs to the oldest accepted command; every
    // BURST words retire one command. Words are forwarded unless flushed.
    task automatic word(input logic [DN-1:0] d);
        rsp_valid = 1'b1;
        rsp_data  = d;
        if (model_pending > 0) begin
            if (!discard && !flush) exp_q.push_back(d);
            model_cnt++;
            if (model_cnt == BURST) begin
                model_cnt = 0;
                model_pending--;
            end
        end
        step();
        rsp_valid = 1'b0;
    endtask

    task automatic issue(input logic [AN-1:0] a, input int dly, output time t_ack);
        int n;
        n = 0;
        req = 1'b1;
        req_addr = a;
        #1;
        while (!req_ack && n < 100) begin
            step();
            n++;
        end
        t_ack = $time;
        check("req_ack", req_ack, 1);
        step();
        req = 1'b0;
        req_addr = AN'($urandom);
        check("cmd_addr", cmd_addr, a);
        for (int i = 0; i < dly; i++) begin
            check("cmd_req_hold", cmd_req, 1);
            step();
        end
        check("cmd_req", cmd_req, 1);
        cmd_ack = 1'b1;
        model_pending++;
        step();
        cmd_ack = 1'b0;
    endtask

    // monitor: pops the scoreboard whenever the DUT presents a word
    always @(negedge clkSYS) begin
        if (mem_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                $display("FAIL stray_word: got mem_valid with data %0h, expected no word", mem_data);
            end else begin
                check("mem_data", mem_data, exp_q.pop_front());
            end
        end
    end

    task automatic check_idle_outputs(input string tag);
        check({tag, "_req_ack"}, req_ack, 0);
        check({tag, "_cmd_req"}, cmd_req, 0);
        check({tag, "_mem_valid"}, mem_valid, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_cmd_addr"}, cmd_addr, 0);
        check({tag, "_mem_data"}, mem_data, 0);
        check({tag, "_pending"}, pending, 0);
        check({tag, "_state"}, state_dbg, IDLE);
    endtask

    initial begin
        time t_ack;
        time t_done;
        int  ncmd;

        step();
        step();
        check_idle_outputs("reset");
        n_reset = 1'b1;
        step();

        // single burst
        issue(24'h000100, 2, t_ack);
        check("single_pending_1", pending, 1);
        check("single_busy", busy, 1);
        for (int i = 1; i <= BURST; i++) word(DN'(16'h1111 * i));
        check("single_pending_0", pending, 0);
        step();
        check("single_busy_0", busy, 0);

        // back-to-back, third request stalls until first burst completes
        issue(24'h000A00, 0, t_ack);
        issue(24'h000B00, 1, t_ack);
        check("b2b_pending_2", pending, 2);
        t_done = 0;
        fork
            issue(24'h000C00, 0, t_ack);
            begin
                repeat (3) step();
                for (int i = 0; i < BURST; i++) word(DN'($urandom));
                t_done = $time;
            end
        join
        check("stall_until_burst_end", (t_done != 0) && (t_ack >= t_done), 1);
        check("b2b_pending_after", pending, 2);
        for (int i = 0; i < 2 * BURST; i++) word(DN'($urandom));
        check("b2b_pending_0", pending, 0);

        // cmd_ack coincides with the last word of the previous burst
        issue(24'h000200, 1, t_ack);
        for (int i = 0; i < BURST - 1; i++) word(DN'($urandom));
        req = 1'b1;
        req_addr = 24'h000280;
        #1;
        check("same_req_ack", req_ack, 1);
        step();
        req = 1'b0;
        check("same_cmd_req", cmd_req, 1);
        cmd_ack = 1'b1;
        word(DN'($urandom));
        cmd_ack = 1'b0;
        model_pending++;
        check("same_cycle_pending", pending, 1);
        for (int i = 0; i < BURST; i++) word(DN'($urandom));
        check("same_pending_0", pending, 0);

        // flush while a command is waiting for cmd_ack
        issue(24'h000300, 0, t_ack);
        req = 1'b1;
        req_addr = 24'h000400;
        #1;
        check("flush_cmd_req_ack", req_ack, 1);
        step();
        req = 1'b0;
        check("flush_cmd_addr", cmd_addr, 24'h000400);
        flush = 1'b1;
        discard = 1'b1;
        step();
        flush = 1'b0;
        check("flush_cmd_req_held", cmd_req, 1);
        check("flush_state_cmd", state_dbg, CMD);
        step();
        check("flush_cmd_req_held2", cmd_req, 1);
        cmd_ack = 1'b1;
        model_pending++;
        step();
        cmd_ack = 1'b0;
        check("flush_pending_2", pending, 2);
        check("flush_state_drain", state_dbg, DRAIN);
        check("flush_cmd_req_low", cmd_req, 0);
        for (int i = 0; i < 2 * BURST; i++) word(DN'($urandom));
        check("flush_pending_0", pending, 0);
        step();
        check("flush_exit_idle", state_dbg, IDLE);
        discard = 1'b0;

        // flush in IDLE with nothing pending
        flush = 1'b1;
        req = 1'b1;
        req_addr = 24'h000500;
        #1;
        check("idle_flush_no_ack", req_ack, 0);
        step();
        check("idle_flush_drain", state_dbg, DRAIN);
        check("idle_flush_no_ack2", req_ack, 0);
        flush = 1'b0;
        step();
        check("idle_flush_back", state_dbg, IDLE);
        check("idle_flush_ack_after", req_ack, 1);
        step();
        req = 1'b0;
        check("idle_flush_cmd_addr", cmd_addr, 24'h000500);
        cmd_ack = 1'b1;
        model_pending++;
        step();
        cmd_ack = 1'b0;
        for (int i = 0; i < BURST; i++) word(DN'($urandom));

        // randomized traffic
        for (int it = 0; it < 12; it++) begin
            ncmd = $urandom_range(1, MAXOUT);
            for (int c = 0; c < ncmd; c++) issue(AN'($urandom), $urandom_range(0, 3), t_ack);
            for (int w = 0; w < ncmd * BURST; w++) begin
                repeat ($urandom_range(0, 1)) step();
                word(DN'($urandom));
            end
            check("rand_pending_0", pending, 0);
        end

        // reset in the middle of a burst
        issue(24'h000600, 1, t_ack);
        for (int i = 0; i < 3; i++) word(DN'($urandom));
        step();
        n_reset = 1'b0;
        model_pending = 0;
        model_cnt = 0;
        #1;
        check_idle_outputs("midreset");
        step();
        n_reset = 1'b1;
        for (int i = 0; i < 5; i++) word(DN'($urandom));
        step();
        check("post_reset_pending", pending, 0);
        check("post_reset_mem_valid", mem_valid, 0);

        step();
        check("scoreboard_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/fb_burst_reader.md
# fb_burst_reader

Burst read engine between the TFT display controller's memory request port and the SDRAM controller's generic read channel. It accepts one-burst address requests from the display side and issues them as fixed-length read commands, with at most MAXOUT commands outstanding. Returned words go back to the display FIFO with one cycle of latency. A flush input discards every in-flight burst at vblank, so stale words never reach the FIFO after it is cleared.

## Interface
- AN, 24: address width.
- DN, 16: data width.
- BURST, 8: words per burst; power of two, 2..32.
- MAXOUT, 2: maximum outstanding commands, 1..3.
- clkSYS  in  1  system clock; all logic is on its rising edge.
- n_reset  in  1  asynchronous active-low reset.
- flush  in  1  discard request; synchronous to clkSYS, synchronised upstream.
- req  in  1  display requests one burst at req_addr.
- req_addr  in  AN  burst start address; sampled when req_ack is 1.
- req_ack  out  1  one-cycle pulse: request accepted.
- mem_data  out  DN  read word to the display FIFO.
- mem_valid  out  1  mem_data is valid this cycle.
- cmd_req  out  1  read command to the SDRAM controller.
- cmd_addr  out  AN  command address; stable while cmd_req is 1.
- cmd_ack  in  1  controller accepted the command.
- rsp_data  in  DN  controller read data.
- rsp_valid  in  1  rsp_data is valid.
- pending  out  2  outstanding command count (debug).
- busy  out  1  state is not IDLE, or pending is not 0.

## Operation
- FSM states: IDLE, CMD, DRAIN.
- IDLE -> CMD when req is 1, flush is 0 and pending < MAXOUT.
  - In that cycle: req_ack pulses and req_addr is latched into cmd_addr.
- CMD: cmd_req is held at 1.
  - On cmd_ack: pending increments; go to IDLE.
  - The next acceptance can happen no earlier than the cycle after cmd_ack.
- Word counter, log2(BURST) bits:
  - Increments on each rsp_valid.
  - On the wrap from BURST-1 to 0, pending decrements.
  - If cmd_ack and a burst-final word land in the same cycle, pending is unchanged.
- mem_data/mem_valid are rsp_data/rsp_valid registered once, except in DRAIN, where mem_valid is forced to 0.
- flush is 1 in any state:
  - No new acceptance.
  - CMD with cmd_ack not yet seen: the command is still completed. The controller cannot retract it, so cmd_req stays at 1 until cmd_ack and then counts as pending.
  - Next state is DRAIN.
- DRAIN:
  - Responses are consumed and dropped.
  - Exit to IDLE when pending is 0, cmd_req is 0 and flush is 0.
- req while pending == MAXOUT: stalls with no req_ack. The request is held and serviced later.
- Violations:
  - rsp_valid when pending is 0 is a protocol error; the word is dropped and an assertion fires.
  - pending must never exceed MAXOUT.

## Timing
- Reset values:
  - req_ack, cmd_req, mem_valid, busy: 0.
  - cmd_addr, mem_data: 0.
  - pending: 0; word counter: 0; state: IDLE.
- Accept latency: req at cycle t with IDLE and room -> req_ack at t; cmd_req from t+1.
- Data latency: rsp_valid at t -> mem_valid at t+1.
- Reset asserted mid-burst clears everything immediately. Words that arrive afterwards are dropped, because pending is 0.

## Structure
- Shared package fb_pkg holds:
  - enum fb_rd_state_t {IDLE, CMD, DRAIN};
  - function clog2 for the counter width.
- No sub-modules; this is a single flat module.

## Test plan
- Single burst, BURST=8: req at addr 0x000100 -> req_ack 1 cycle, cmd_addr=0x000100, cmd_req until cmd_ack. 8 rsp words 0x1111..0x8888 -> identical mem_data, each one cycle later; pending goes 1 -> 0.
- Back-to-back requests, MAXOUT=2, controller withholds data: 2 acks. A third req stalls with no req_ack until the first burst's 8th word, then is acked.
- Same-cycle event: cmd_ack coincides with the last word of the previous burst -> pending is unchanged (1 stays 1).
- Flush in CMD, cmd_ack not yet seen, 1 burst outstanding: cmd_req stays until ack, pending becomes 2. All 16 words are dropped with mem_valid 0, then IDLE.
- Flush in IDLE with pending=0 -> DRAIN for one cycle, then IDLE once flush drops. No req_ack while flush is 1.
- Reset mid-burst after 3 words: all outputs are 0 the next edge. The 5 trailing words produce no mem_valid.
